dark_imm_pipe: RTL and testbench

//  Pipelined immediate pre-decoder between fetch and the decode/execute stage.

---
 rtl/dark_imm_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_dark_imm_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dark_imm_pipe.sv
// dark_imm_pipe: RV32I immediate pre-decoder, one instruction per cycle,
// valid/ready in and out, two-entry (OUT + SKID) storage, 1-cycle latency.
// Ports:
//   CLK, RES (async, active-high), HLT (freeze), FLUSH (drop all entries)
//   IVLD/IRDY/IDATA : instruction input handshake
//   OVLD/ORDY       : output handshake
//   SIMM/UIMM       : sign-/zero-extended immediate, XLEN bits
//   ITYPE/ILL       : 0=I 1=S 2=B 3=U 4=J 5=R 7=illegal; ILL = (ITYPE==7)
module dark_imm_pipe #(
  parameter int XLEN   = 32,
  parameter bit EN_MAC = 1'b1
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic            HLT,
  input  logic            FLUSH,
  input  logic            IVLD,
  output logic            IRDY,
  input  logic [31:0]     IDATA,
  output logic            OVLD,
  input  logic            ORDY,
  output logic [XLEN-1:0] SIMM,
  output logic [XLEN-1:0] UIMM,
  output logic [2:0]      ITYPE,
  output logic            ILL
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_MAC   = 7'b1111111;

  localparam logic [2:0] C_I   = 3'd0;
  localparam logic [2:0] C_S   = 3'd1;
  localparam logic [2:0] C_B   = 3'd2;
  localparam logic [2:0] C_U   = 3'd3;
  localparam logic [2:0] C_J   = 3'd4;
  localparam logic [2:0] C_R   = 3'd5;
  localparam logic [2:0] C_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] simm;
    logic [XLEN-1:0] uimm;
    logic [2:0]      ityp;
  } ent_t;

  typedef enum logic [1:0] {
    OCC0 = 2'd0,
    OCC1 = 2'd1,
    OCC2 = 2'd2
  } occ_t;

  // ---------------- decode (input side) ----------------
  logic [6:0]  op;
  logic        is_i, is_s, is_b, is_j, is_u, is_r;
  logic [31:0] s32, u32;
  logic [2:0]  cls;

  assign op   = IDATA[6:0];
  assign is_i = (op == OP_LOAD) | (op == OP_IMM) | (op == OP_JALR)
              | (op == OP_FENCE) | (op == OP_SYS);
  assign is_s = (op == OP_STORE);
  assign is_b = (op == OP_BR);
  assign is_j = (op == OP_JAL);
  assign is_u = (op == OP_LUI) | (op == OP_AUIPC);
  assign is_r = (op == OP_REG) | (EN_MAC & (op == OP_MAC));

  always_comb begin
    s32 = '0;
    u32 = '0;
    cls = C_ILL;
    unique case (1'b1)
      is_i: begin
        cls = C_I;
        u32 = {20'b0, IDATA[31:20]};
        s32 = {{20{IDATA[31]}}, IDATA[31:20]};
      end
      is_s: begin
        cls = C_S;
        u32 = {20'b0, IDATA[31:25], IDATA[11:7]};
        s32 = {{20{IDATA[31]}}, IDATA[31:25], IDATA[11:7]};
      end
      is_b: begin
        cls = C_B;
        u32 = {19'b0, IDATA[31], IDATA[7],
               IDATA[30:25], IDATA[11:8], 1'b0};
        s32 = {{19{IDATA[31]}}, IDATA[31], IDATA[7],
               IDATA[30:25], IDATA[11:8], 1'b0};
      end
      is_u: begin
        cls = C_U;
        u32 = {IDATA[31:12], 12'b0};
        s32 = {IDATA[31:12], 12'b0};
      end
      is_j: begin
        cls = C_J;
        u32 = {11'b0, IDATA[31], IDATA[19:12],
               IDATA[20], IDATA[30:21], 1'b0};
        s32 = {{11{IDATA[31]}}, IDATA[31], IDATA[19:12],
               IDATA[20], IDATA[30:21], 1'b0};
      end
      is_r: begin
        cls = C_R;
      end
      default: begin
        cls = C_ILL;
      end
    endcase
  end

  logic [XLEN-1:0] dec_simm, dec_uimm;

  // 32-bit immediates are already class-extended; widen for RV64.
  if (XLEN == 64) begin : g_x64
    assign dec_simm = {{32{s32[31]}}, s32};
    assign dec_uimm = {32'b0, u32};
  end else begin : g_x32
    assign dec_simm = s32;
    assign dec_uimm = u32;
  end

  ent_t dec;
  assign dec = '{simm: dec_simm, uimm: dec_uimm, ityp: cls};

  // ---------------- occupancy control ----------------
  occ_t occ, occ_nxt;
  ent_t out_q, skid_q;
  logic in_x, out_x;
  logic ld_out, ld_skid, sel_skid;

  // Ready depends on registered occupancy only, never on ORDY.
  assign IRDY  = ~RES & ~HLT & (occ != OCC2);
  assign OVLD  = ~HLT & (occ != OCC0);
  assign in_x  = IVLD & IRDY;
  assign out_x = OVLD & ORDY;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) occ <= OCC0;
    else     occ <= occ_nxt;
  end

  always_comb begin
    occ_nxt  = occ;
    ld_out   = 1'b0;
    ld_skid  = 1'b0;
    sel_skid = 1'b0;
    if (HLT) begin
      occ_nxt = occ;
    end else if (FLUSH) begin
      occ_nxt = OCC0;
    end else begin
      unique case (occ)
        OCC0: begin
          if (in_x) begin
            ld_out  = 1'b1;
            occ_nxt = OCC1;
          end
        end
        OCC1: begin
          unique case (1'b1)
            in_x & out_x: begin
              ld_out = 1'b1;
            end
            in_x & ~out_x: begin
              ld_skid = 1'b1;
              occ_nxt = OCC2;
            end
            ~in_x & out_x: begin
              occ_nxt = OCC0;
            end
            default: begin
              occ_nxt = OCC1;
            end
          endcase
        end
        OCC2: begin
          if (out_x) begin
            ld_out   = 1'b1;
            sel_skid = 1'b1;
            occ_nxt  = OCC1;
          end
        end
        default: begin
          occ_nxt = OCC0;
        end
      endcase
    end
  end

  // ---------------- entry storage ----------------
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (ld_out)  out_q  <= sel_skid ? skid_q : dec;
      if (ld_skid) skid_q <= dec;
    end
  end

  assign SIMM  = out_q.simm;
  assign UIMM  = out_q.uimm;
  assign ITYPE = out_q.ityp;
  assign ILL   = (out_q.ityp == C_ILL);

endmodule

// File: tb/tb_dark_imm_pipe.sv
// tb_dark_imm_pipe: directed + random check of dark_imm_pipe
// (XLEN=32/EN_MAC=1 and XLEN=64/EN_MAC=0 side by side).
module tb_dark_imm_pipe;

  logic        CLK = 1'b0;
  logic        RES, HLT, FLUSH, IVLD, ORDY;
  logic [31:0] IDATA;

  logic        irdy_a, ovld_a, ill_a;
  logic [31:0] simm_a, uimm_a;
  logic [2:0]  ityp_a;

  logic        irdy_b, ovld_b, ill_b;
  logic [63:0] simm_b, uimm_b;
  logic [2:0]  ityp_b;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] q[$];

  always #5 CLK = ~CLK;

  dark_imm_pipe #(.XLEN(32), .EN_MAC(1'b1)) u_dut32 (
    .CLK(CLK), .RES(RES), .HLT(HLT), .FLUSH(FLUSH),
    .IVLD(IVLD), .IRDY(irdy_a), .IDATA(IDATA),
    .OVLD(ovld_a), .ORDY(ORDY),
    .SIMM(simm_a), .UIMM(uimm_a), .ITYPE(ityp_a), .ILL(ill_a)
  );

  dark_imm_pipe #(.XLEN(64), .EN_MAC(1'b0)) u_dut64 (
    .CLK(CLK), .RES(RES), .HLT(HLT), .FLUSH(FLUSH),
    .IVLD(IVLD), .IRDY(irdy_b), .IDATA(IDATA),
    .OVLD(ovld_b), .ORDY(ORDY),
    .SIMM(simm_b), .UIMM(uimm_b), .ITYPE(ityp_b), .ILL(ill_b)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode: raw field value plus sign by subtracting 2^nb.
  function automatic void ref_dec(input logic [31:0] w, input bit x64,
                                  input bit mac, output logic [63:0] s,
                                  output logic [63:0] u,
                                  output logic [2:0] t);
    int nb;
    nb = 0;
    u  = 64'd0;
    t  = 3'd7;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin
        t = 3'd0; nb = 12; u = 64'(w[31:20]);
      end
      7'h23: begin
        t = 3'd1; nb = 12; u = 64'({w[31:25], w[11:7]});
      end
      7'h63: begin
        t = 3'd2; nb = 13;
        u = 64'({w[31], w[7], w[30:25], w[11:8], 1'b0});
      end
      7'h37, 7'h17: begin
        t = 3'd3; nb = 32; u = 64'({w[31:12], 12'b0});
      end
      7'h6F: begin
        t = 3'd4; nb = 21;
        u = 64'({w[31], w[19:12], w[20], w[30:21], 1'b0});
      end
      7'h33: t = 3'd5;
      7'h7F: t = mac ? 3'd5 : 3'd7;
      default: t = 3'd7;
    endcase
    s = u;
    if (nb > 0 && u[nb-1]) s = u - (64'd1 << nb);
    if (!x64) s = s & 64'h0000_0000_FFFF_FFFF;
  endfunction

  task automatic model_chk();
    logic        er, eo;
    logic [63:0] s, u;
    logic [2:0]  t;
    er = !RES && !HLT && q.size() < 2;
    eo = !RES && !HLT && q.size() > 0;
    chk("irdy32", irdy_a, er);
    chk("irdy64", irdy_b, er);
    chk("ovld32", ovld_a, eo);
    chk("ovld64", ovld_b, eo);
    if (q.size() > 0) begin
      ref_dec(q[0], 1'b0, 1'b1, s, u, t);
      chk("simm32", simm_a, s);
      chk("uimm32", uimm_a, u);
      chk("ityp32", ityp_a, t);
      chk("ill32", ill_a, t == 3'd7);
      ref_dec(q[0], 1'b1, 1'b0, s, u, t);
      chk("simm64", simm_b, s);
      chk("uimm64", uimm_b, u);
      chk("ityp64", ityp_b, t);
      chk("ill64", ill_b, t == 3'd7);
    end
    if (RES) begin
      chk("rst_simm32", simm_a, 0);
      chk("rst_uimm32", uimm_a, 0);
      chk("rst_ityp32", ityp_a, 0);
      chk("rst_ill32", ill_a, 0);
      chk("rst_simm64", simm_b, 0);
      chk("rst_uimm64", uimm_b, 0);
      chk("rst_ityp64", ityp_b, 0);
      chk("rst_ill64", ill_b, 0);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] d, input bit r,
                      input bit h, input bit f, input bit rs);
    bit ei, eo;
    @(negedge CLK);
    IVLD = v; IDATA = d; ORDY = r;
    HLT = h; FLUSH = f; RES = rs;
    if (rs) q.delete();
    #1;
    model_chk();
    ei = v && !rs && !h && q.size() < 2;
    eo = r && !rs && !h && q.size() > 0;
    @(posedge CLK);
    if (!rs && !h) begin
      if (f) q.delete();
      else begin
        if (eo) void'(q.pop_front());
        if (ei) q.push_back(d);
      end
    end
  endtask

  task automatic lit(input string tag, input logic [31:0] s32,
                     input logic [31:0] u32, input logic [2:0] t32,
                     input logic [63:0] s64, input logic [63:0] u64,
                     input logic [2:0] t64);
    #1;
    chk({tag, ".ovld"}, ovld_a, 1);
    chk({tag, ".simm32"}, simm_a, s32);
    chk({tag, ".uimm32"}, uimm_a, u32);
    chk({tag, ".ityp32"}, ityp_a, t32);
    chk({tag, ".ill32"}, ill_a, t32 == 3'd7);
    chk({tag, ".simm64"}, simm_b, s64);
    chk({tag, ".uimm64"}, uimm_b, u64);
    chk({tag, ".ityp64"}, ityp_b, t64);
    chk({tag, ".ill64"}, ill_b, t64 == 3'd7);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 13);
    case (k)
      0:  w[6:0] = 7'h03;
      1:  w[6:0] = 7'h13;
      2:  w[6:0] = 7'h67;
      3:  w[6:0] = 7'h0F;
      4:  w[6:0] = 7'h73;
      5:  w[6:0] = 7'h23;
      6:  w[6:0] = 7'h63;
      7:  w[6:0] = 7'h37;
      8:  w[6:0] = 7'h17;
      9:  w[6:0] = 7'h6F;
      10: w[6:0] = 7'h33;
      11: w[6:0] = 7'h7F;
      12: w[6:0] = 7'h0B;
      default: ;
    endcase
    return w;
  endfunction

  localparam logic [31:0] A = 32'h0050_0113;
  localparam logic [31:0] B = 32'h00A0_0193;
  localparam logic [31:0] C = 32'h00F0_0213;

  initial begin
    RES = 1'b1; HLT = 1'b0; FLUSH = 1'b0;
    IVLD = 1'b0; ORDY = 1'b0; IDATA = '0;

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst.irdy", irdy_a, 0);
    chk("rst.ovld", ovld_a, 0);
    step(0, 0, 0, 0, 0, 0);
    #1;
    chk("rel.irdy", irdy_a, 1);

    // single-instruction decode examples
    step(1, 32'hFFF0_0093, 1, 0, 0, 0);
    lit("addi", 32'hFFFF_FFFF, 32'h0000_0FFF, 3'd0,
        64'hFFFF_FFFF_FFFF_FFFF, 64'h0FFF, 3'd0);
    step(1, 32'hFE11_2E23, 1, 0, 0, 0);
    lit("sw", 32'hFFFF_FFFC, 32'h0000_0FFC, 3'd1,
        64'hFFFF_FFFF_FFFF_FFFC, 64'h0FFC, 3'd1);
    step(1, 32'hFE00_0EE3, 1, 0, 0, 0);
    lit("beq", 32'hFFFF_FFFC, 32'h0000_1FFC, 3'd2,
        64'hFFFF_FFFF_FFFF_FFFC, 64'h1FFC, 3'd2);
    step(1, 32'h0080_006F, 1, 0, 0, 0);
    lit("jal", 32'd8, 32'd8, 3'd4, 64'd8, 64'd8, 3'd4);
    step(1, 32'h8000_0037, 1, 0, 0, 0);
    lit("lui", 32'h8000_0000, 32'h8000_0000, 3'd3,
        64'hFFFF_FFFF_8000_0000, 64'h8000_0000, 3'd3);
    step(1, 32'h0000_000B, 1, 0, 0, 0);
    lit("ill", 32'd0, 32'd0, 3'd7, 64'd0, 64'd0, 3'd7);
    step(1, 32'h0000_007F, 1, 0, 0, 0);
    lit("mac", 32'd0, 32'd0, 3'd5, 64'd0, 64'd0, 3'd7);
    step(0, 0, 1, 0, 0, 0);

    // backpressure: A,B stored, C held, then drained in order
    step(1, A, 0, 0, 0, 0);
    step(1, B, 0, 0, 0, 0);
    step(1, C, 0, 0, 0, 0);
    #1;
    chk("bp.irdy", irdy_a, 0);
    chk("bp.head", simm_a, 5);
    step(1, C, 1, 0, 0, 0);
    #1;
    chk("bp.second", simm_a, 10);
    step(1, C, 1, 0, 0, 0);
    #1;
    chk("bp.third", simm_a, 15);
    step(0, 0, 1, 0, 0, 0);
    #1;
    chk("bp.empty", ovld_a, 0);

    // flush at full occupancy, with a same-cycle input
    step(1, A, 0, 0, 0, 0);
    step(1, B, 0, 0, 0, 0);
    step(1, C, 0, 0, 1, 0);
    #1;
    chk("flush.ovld", ovld_a, 0);
    chk("flush.irdy", irdy_a, 1);

    // halt with one entry held
    step(1, A, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, B, 1, 1, 0, 0);
      #1;
      chk("hlt.ovld", ovld_a, 0);
      chk("hlt.irdy", irdy_a, 0);
      chk("hlt.simm", simm_a, 5);
    end
    step(0, 0, 0, 0, 0, 0);
    #1;
    chk("hlt.back.ovld", ovld_a, 1);
    chk("hlt.back.simm", simm_a, 5);

    // asynchronous reset mid-stream
    step(1, B, 0, 0, 0, 0);
    step(1, C, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rnd_instr(),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 31) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
